line_clear_ctrl: RTL and testbench
==================================

// Module: line_clear_ctrl
// PURPOSE
//  Sequences row clearing on the Tetris board after each piece locks: scans rows bottom-up,
//  collapses every full row by shifting all rows above it down one, zeroes the top row.
//  Sits between the piece-movement logic (issues lock_valid, stalls spawn while busy)
//  and the board row store (single-port, combinational read). Reports lines cleared per lock.
// PARAMETERS
//  BOARD_W       12  playfield columns; row full when row[BOARD_W-1:0] all ones
//  BOARD_H       19  playfield rows; row 0 = top, BOARD_H-1 = bottom
//  FLASH_FRAMES  8   frames full rows are flagged before collapse (LINE_FLASH_EN only)
// PORTS
//  frame_clk     in   1   clock, one edge per video frame
//  Reset         in   1   asynchronous, active-high
//  lock_valid    in   1   piece locked into board this cycle; accepted only when lock_ready=1
//  lock_ready    out  1   high in IDLE
//  busy          out  1   high in every state except IDLE; piece spawn must stall
//  row_addr      out  5   board row address (read and write)
//  row_rdata     in   16  board row at row_addr, combinational
//  row_wdata     out  16  write data
//  row_we        out  1   write strobe, row_wdata -> row row_addr at frame_clk edge
//  clear_done    out  1   one-cycle pulse at end of each accepted lock
//  lines_cleared out  3   full rows removed by last lock, valid with clear_done, held until next
//  total_lines   out  16  running sum of cleared rows, saturates at 16'hFFFF
//  flash_mask    out  19  bit r = row r marked full (port exists only with LINE_FLASH_EN)
// BEHAVIOUR
//  Reset: state IDLE; lock_ready=1, busy=0, row_we=0, row_addr=0, row_wdata=0, clear_done=0,
//   lines_cleared=0, total_lines=0, flash_mask=0. Board contents not touched.
//  States: IDLE, SCAN, SHIFT_RD, SHIFT_WR, CLR_TOP, DONE (+MARK, FLASH with macro).
//  IDLE: lock_valid=1 -> SCAN, r=BOARD_H-1, count=0. lock_valid ignored in all other states.
//  SCAN: row_addr=r. Full -> count+=1 (sat 7); r==0 -> CLR_TOP, else d=r, SHIFT_RD.
//   Not full -> r==0 ? DONE : r-=1.
//  SHIFT_RD: row_addr=d-1, latch row_rdata into buf -> SHIFT_WR.
//  SHIFT_WR: row_addr=d, row_wdata=buf, row_we=1; d-=1; d==0 -> CLR_TOP else SHIFT_RD.
//  CLR_TOP: row_addr=0, row_wdata=0, row_we=1 -> SCAN with same r (rescan shifted-in row).
//  DONE: clear_done=1, lines_cleared=count, total_lines+=count (saturating) -> IDLE.
//  Latency, no full rows: clear_done high exactly BOARD_H+1 cycles after accept edge (20).
//   Each full row at index r adds 2r+2 cycles (row 0: 2 cycles).
//  row_we is never high outside SHIFT_WR/CLR_TOP; only one row access per cycle.
//  Reset mid-operation: returns to IDLE immediately, row_we drops asynchronously; partially
//   shifted board is left as-is (board owner clears it on the same Reset).
//  Bits [15:BOARD_W] of rows are moved unchanged, never inspected.
// CONFIGURATION
//  LINE_FLASH_EN defined: accept -> MARK pass (BOARD_H cycles, reads only) sets flash_mask;
//   mask!=0 -> FLASH for FLASH_FRAMES cycles, then SCAN as above; mask==0 -> DONE directly.
//   flash_mask cleared on entry to DONE. Latency figures shift accordingly.
//  Undefined: no MARK/FLASH states, no flash_mask port, no frame counter.
// STRUCTURE
//  Package tetris_pkg: BOARD_W, BOARD_H, typedef logic [15:0] row_t, lc_state_e enum.
//  Sub-module row_full_check: row_t in, BOARD_W param, 1-bit full out (all-ones reduce).
//  Everything else inline: one FSM, r/d counters, buf register, count, total_lines.
// TESTING
//  1 Empty board, lock pulse -> 19 reads, row_we never 1, clear_done in cycle 20, lines_cleared=0.
//  2 Row18=0FFF, row17=0005 -> row18=0005, row0=0000, lines_cleared=1, total_lines=1.
//  3 Rows15-18=0FFF, rows11-14=0001..0004 -> rows15-18=0001..0004, rows0-3=0, lines_cleared=4.
//  4 Rows 18 and 16 full, row17=0AAA -> row18=0AAA, lines_cleared=2; row0 full alone -> cleared.
//  5 lock_valid during busy ignored (total_lines unchanged); Reset in SHIFT_WR -> row_we=0
//    same cycle, busy=0, total_lines=0.
//  6 LINE_FLASH_EN: row18 full -> flash_mask=1<<18 for 8 cycles before first row_we, then 0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry, row type and line-clear FSM state encoding.
// MARK/FLASH encodings are only reached when LINE_FLASH_EN is defined.
package tetris_pkg;

   localparam int BOARD_W      = 12;
   localparam int BOARD_H      = 19;
   localparam int FLASH_FRAMES = 8;
   localparam int ROW_AW       = 5;

   typedef logic [15:0] row_t;

   typedef enum logic [2:0] {
      LC_IDLE,
      LC_SCAN,
      LC_SHIFT_RD,
      LC_SHIFT_WR,
      LC_CLR_TOP,
      LC_DONE,
      LC_MARK,
      LC_FLASH
   } lc_state_e;

   // Running line total sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_add_lines(input logic [15:0] total, input logic [2:0] add);
      logic [16:0] sum;
      sum = {1'b0, total} + {14'b0, add};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/line_clear_row_full_check.sv
// Flags a board row as full when every playfield column bit is set.
// Bits above BOARD_W-1 are deliberately ignored.
module row_full_check #(
   parameter int BOARD_W = 12
) (
   input  tetris_pkg::row_t row_i,
   output logic             full_o
);

   assign full_o = &row_i[BOARD_W-1:0];

endmodule

// File: rtl/line_clear_ctrl.sv
// Bottom-up line-clear sequencer: scans rows, collapses each full row, zeroes the top row.
// Optional LINE_FLASH_EN adds a read-only MARK pass and a FLASH hold before collapsing.
module line_clear_ctrl
   import tetris_pkg::*;
(
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic        lock_valid,
   output logic        lock_ready,
   output logic        busy,
   output logic [4:0]  row_addr,
   input  logic [15:0] row_rdata,
   output logic [15:0] row_wdata,
   output logic        row_we,
   output logic        clear_done,
   output logic [2:0]  lines_cleared,
   output logic [15:0] total_lines
`ifdef LINE_FLASH_EN
  ,output logic [BOARD_H-1:0] flash_mask
`endif
);

   localparam logic [ROW_AW-1:0] ROW_BOT = ROW_AW'(BOARD_H - 1);

   lc_state_e         state_q, state_d;
   logic [ROW_AW-1:0] r_q, r_d;
   logic [ROW_AW-1:0] d_q, d_d;
   row_t              rbuf_q, rbuf_d;
   logic [2:0]        count_q, count_d;
   logic [2:0]        lines_q, lines_d;
   logic [15:0]       total_q, total_d;
   logic              row_full;
   logic              go_done;

`ifdef LINE_FLASH_EN
   localparam int FRAME_W = $clog2(FLASH_FRAMES);
   logic [BOARD_H-1:0] mask_q, mask_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
`endif

   row_full_check #(.BOARD_W(BOARD_W)) u_full (
      .row_i  (row_rdata),
      .full_o (row_full)
   );

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q <= LC_IDLE;
         r_q     <= '0;
         d_q     <= '0;
         rbuf_q  <= '0;
         count_q <= '0;
         lines_q <= '0;
         total_q <= '0;
`ifdef LINE_FLASH_EN
         mask_q  <= '0;
         frame_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         d_q     <= d_d;
         rbuf_q  <= rbuf_d;
         count_q <= count_d;
         lines_q <= lines_d;
         total_q <= total_d;
`ifdef LINE_FLASH_EN
         mask_q  <= mask_d;
         frame_q <= frame_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      d_d        = d_q;
      rbuf_d     = rbuf_q;
      count_d    = count_q;
      lines_d    = lines_q;
      total_d    = total_q;
      go_done    = 1'b0;
      row_addr   = '0;
      row_wdata  = '0;
      row_we     = 1'b0;
      clear_done = 1'b0;
`ifdef LINE_FLASH_EN
      mask_d     = mask_q;
      frame_d    = frame_q;
`endif
      unique case (state_q)
         LC_IDLE: begin
            if (lock_valid) begin
               r_d     = ROW_BOT;
               count_d = '0;
`ifdef LINE_FLASH_EN
               state_d = LC_MARK;
`else
               state_d = LC_SCAN;
`endif
            end
         end
`ifdef LINE_FLASH_EN
         LC_MARK: begin
            row_addr = r_q;
            if (row_full) mask_d[r_q] = 1'b1;
            if (r_q == '0) begin
               if (mask_d != '0) begin
                  frame_d = '0;
                  state_d = LC_FLASH;
               end else begin
                  go_done = 1'b1;
               end
            end else begin
               r_d = r_q - 1'b1;
            end
         end
         LC_FLASH: begin
            if (frame_q == FRAME_W'(FLASH_FRAMES - 1)) begin
               r_d     = ROW_BOT;
               state_d = LC_SCAN;
            end else begin
               frame_d = frame_q + 1'b1;
            end
         end
`endif
         LC_SCAN: begin
            row_addr = r_q;
            if (row_full) begin
               if (count_q != 3'd7) count_d = count_q + 3'd1;
               if (r_q == '0) begin
                  state_d = LC_CLR_TOP;
               end else begin
                  d_d     = r_q;
                  state_d = LC_SHIFT_RD;
               end
            end else if (r_q == '0) begin
               go_done = 1'b1;
            end else begin
               r_d = r_q - 1'b1;
            end
         end
         LC_SHIFT_RD: begin
            row_addr = d_q - 1'b1;
            rbuf_d   = row_rdata;
            state_d  = LC_SHIFT_WR;
         end
         LC_SHIFT_WR: begin
            row_addr  = d_q;
            row_wdata = rbuf_q;
            row_we    = 1'b1;
            d_d       = d_q - 1'b1;
            state_d   = (d_q == ROW_AW'(1)) ? LC_CLR_TOP : LC_SHIFT_RD;
         end
         LC_CLR_TOP: begin
            // r is unchanged so the row that just dropped into it is examined again.
            row_we  = 1'b1;
            state_d = LC_SCAN;
         end
         LC_DONE: begin
            clear_done = 1'b1;
            state_d    = LC_IDLE;
         end
         default: state_d = LC_IDLE;
      endcase

      // Result registers load on entry so they are already valid during the DONE pulse.
      if (go_done) begin
         state_d = LC_DONE;
         lines_d = count_q;
         total_d = sat_add_lines(total_q, count_q);
`ifdef LINE_FLASH_EN
         mask_d  = '0;
`endif
      end
   end

   assign lock_ready    = (state_q == LC_IDLE);
   assign busy          = (state_q != LC_IDLE);
   assign lines_cleared = lines_q;
   assign total_lines   = total_q;
`ifdef LINE_FLASH_EN
   assign flash_mask    = mask_q;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a behavioural row store and hand-computed results.
// LINE_FLASH_EN builds add the flash-mask check and the MARK/FLASH latency offset.
module tb_line_clear_ctrl;

   logic        frame_clk = 1'b0;
   logic        Reset = 1'b1;
   logic        lock_valid = 1'b0;
   logic        lock_ready, busy, row_we, clear_done;
   logic [4:0]  row_addr;
   logic [15:0] row_rdata, row_wdata, total_lines;
   logic [2:0]  lines_cleared;
`ifdef LINE_FLASH_EN
   logic [18:0] flash_mask;
   localparam int FL_OFS = 27;
`else
   localparam int FL_OFS = 0;
`endif

   logic [15:0] board [19];
   logic        ld_en = 1'b0;
   logic [4:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 frame_clk = ~frame_clk;

   line_clear_ctrl dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .lock_valid    (lock_valid),
      .lock_ready    (lock_ready),
      .busy          (busy),
      .row_addr      (row_addr),
      .row_rdata     (row_rdata),
      .row_wdata     (row_wdata),
      .row_we        (row_we),
      .clear_done    (clear_done),
      .lines_cleared (lines_cleared),
      .total_lines   (total_lines)
`ifdef LINE_FLASH_EN
     ,.flash_mask    (flash_mask)
`endif
   );

   assign row_rdata = (row_addr < 5'd19) ? board[row_addr] : 16'h0000;

   always @(posedge frame_clk) begin
      if (row_we && row_addr < 5'd19) board[row_addr] <= row_wdata;
      else if (ld_en) board[ld_addr] <= ld_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic set_row(input int a, input logic [15:0] v);
      @(negedge frame_clk);
      ld_en = 1'b1; ld_addr = 5'(a); ld_data = v;
      @(posedge frame_clk);
      #1 ld_en = 1'b0;
   endtask

   task automatic clear_board();
      for (int i = 0; i < 19; i++) set_row(i, 16'h0000);
   endtask

   // Accepts one lock and counts cycles from the accept edge up to the clear_done sample.
   task automatic run_lock(input bit hammer, output int cycles, output int we_cnt,
                           output logic [2:0] lc);
      bit done;
      @(negedge frame_clk);
      lock_valid = 1'b1;
      @(posedge frame_clk);
      #1 lock_valid = 1'b0;
      cycles = 0; we_cnt = 0; done = 1'b0; lc = '0;
      while (!done && cycles < 2000) begin
         @(negedge frame_clk);
         cycles++;
         if (row_we) we_cnt++;
         if (clear_done) begin
            done = 1'b1;
            lc   = lines_cleared;
         end
         lock_valid = hammer && !clear_done;
      end
      lock_valid = 1'b0;
      check("done_seen", {31'b0, done}, 32'd1);
      @(negedge frame_clk);
      check("done_pulse_1cyc", {31'b0, clear_done}, 32'd0);
   endtask

   int          cyc, wes;
   logic [2:0]  lc;
   bit          found;

   initial begin
      #12;
      check("rst_lock_ready", {31'b0, lock_ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_row_we", {31'b0, row_we}, 32'd0);
      check("rst_row_addr", {27'b0, row_addr}, 32'd0);
      check("rst_row_wdata", {16'b0, row_wdata}, 32'd0);
      check("rst_clear_done", {31'b0, clear_done}, 32'd0);
      check("rst_lines", {29'b0, lines_cleared}, 32'd0);
      check("rst_total", {16'b0, total_lines}, 32'd0);
      clear_board();
      @(negedge frame_clk);
      Reset = 1'b0;

      // 1: empty board
      run_lock(1'b0, cyc, wes, lc);
      check("t1_latency", cyc, 32'd20);
      check("t1_we_count", wes, 32'd0);
      check("t1_lines", {29'b0, lc}, 32'd0);
      check("t1_total", {16'b0, total_lines}, 32'd0);

      // 2: single full bottom row
      set_row(18, 16'h0FFF);
      set_row(17, 16'h0005);
      run_lock(1'b0, cyc, wes, lc);
      check("t2_latency", cyc, 32'(58 + FL_OFS));
      check("t2_we_count", wes, 32'd19);
      check("t2_row18", {16'b0, board[18]}, 32'h0005);
      check("t2_row17", {16'b0, board[17]}, 32'h0000);
      check("t2_row0", {16'b0, board[0]}, 32'h0000);
      check("t2_lines", {29'b0, lc}, 32'd1);
      check("t2_total", {16'b0, total_lines}, 32'd1);

      // 3: four stacked full rows with a staircase above
      clear_board();
      for (int i = 15; i <= 18; i++) set_row(i, 16'h0FFF);
      for (int i = 11; i <= 14; i++) set_row(i, 16'(i - 10));
      run_lock(1'b0, cyc, wes, lc);
      check("t3_latency", cyc, 32'(172 + FL_OFS));
      for (int i = 15; i <= 18; i++) check($sformatf("t3_row%0d", i), {16'b0, board[i]}, 32'(i - 14));
      for (int i = 0; i <= 14; i++) check($sformatf("t3_row%0d", i), {16'b0, board[i]}, 32'h0);
      check("t3_lines", {29'b0, lc}, 32'd4);
      check("t3_total", {16'b0, total_lines}, 32'd5);

      // 4: split full rows; upper bits ride along and never decide fullness
      clear_board();
      set_row(18, 16'h0FFF);
      set_row(17, 16'h5AAA);
      set_row(16, 16'hFFFF);
      set_row(10, 16'hF7FF);
      run_lock(1'b0, cyc, wes, lc);
      check("t4_latency", cyc, 32'(94 + FL_OFS));
      check("t4_row18", {16'b0, board[18]}, 32'h5AAA);
      check("t4_row17", {16'b0, board[17]}, 32'h0000);
      check("t4_row12", {16'b0, board[12]}, 32'hF7FF);
      check("t4_row10", {16'b0, board[10]}, 32'h0000);
      check("t4_lines", {29'b0, lc}, 32'd2);
      check("t4_total", {16'b0, total_lines}, 32'd7);

      clear_board();
      set_row(0, 16'h0FFF);
      run_lock(1'b0, cyc, wes, lc);
      check("t4b_latency", cyc, 32'(22 + FL_OFS));
      check("t4b_we_count", wes, 32'd1);
      check("t4b_row0", {16'b0, board[0]}, 32'h0000);
      check("t4b_lines", {29'b0, lc}, 32'd1);
      check("t4b_total", {16'b0, total_lines}, 32'd8);

      // 5: lock_valid held high while busy must not restart or double count
      clear_board();
      set_row(18, 16'h0FFF);
      run_lock(1'b1, cyc, wes, lc);
      check("t5_latency", cyc, 32'(58 + FL_OFS));
      repeat (3) @(negedge frame_clk);
      check("t5_idle", {31'b0, lock_ready}, 32'd1);
      check("t5_total", {16'b0, total_lines}, 32'd9);

      // 5b: asynchronous reset in the middle of a shift
      clear_board();
      set_row(18, 16'h0FFF);
      @(negedge frame_clk);
      lock_valid = 1'b1;
      @(posedge frame_clk);
      #1 lock_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge frame_clk);
         if (row_we) found = 1'b1;
      end
      check("t5b_reached_shift", {31'b0, found}, 32'd1);
      Reset = 1'b1;
      #1;
      check("t5b_row_we", {31'b0, row_we}, 32'd0);
      check("t5b_busy", {31'b0, busy}, 32'd0);
      check("t5b_total", {16'b0, total_lines}, 32'd0);
      check("t5b_lines", {29'b0, lines_cleared}, 32'd0);
      @(negedge frame_clk);
      Reset = 1'b0;

`ifdef LINE_FLASH_EN
      // 6: mask visible through FLASH and cleared when DONE is entered
      clear_board();
      set_row(18, 16'h0FFF);
      @(negedge frame_clk);
      lock_valid = 1'b1;
      @(posedge frame_clk);
      #1 lock_valid = 1'b0;
      found = 1'b0;
      cyc = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge frame_clk);
         cyc++;
         if (row_we) found = 1'b1;
      end
      check("t6_first_we_cycle", cyc, 32'd30);
      check("t6_mask_at_we", {13'b0, flash_mask}, 32'h40000);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge frame_clk);
         if (clear_done) found = 1'b1;
      end
      check("t6_done", {31'b0, found}, 32'd1);
      check("t6_mask_cleared", {13'b0, flash_mask}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
